wait_data_memory: RTL and testbench
===================================

WAIT_DATA_MEMORY -- requirements
Module: wait_data_memory

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, byte-address width; depth = 2**ADDR_WIDTH / (DATA_WIDTH/8) words.
REQ-002 Parameter DATA_WIDTH, default 32, word width; legal values 32 and 64.
REQ-003 Parameter LATENCY, default 2, wait-state count; legal range 0..15.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, named as below.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  block can accept a request.
REQ-009 req_write  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  ADDR_WIDTH  byte address.
REQ-011 req_wdata  input  DATA_WIDTH  write data.
REQ-012 req_strb  input  DATA_WIDTH/8  byte write enables.
REQ-013 resp_valid  output  1  response present.
REQ-014 resp_ready  input  1  consumer accepts response.
REQ-015 resp_rdata  output  DATA_WIDTH  read data (reads); 0 for writes.
REQ-016 resp_err  output  1  request was rejected (see REQ-027).

Function
REQ-017 FSM states IDLE, WAIT, RESP; exactly one transaction outstanding at a time.
REQ-018 req_ready SHALL be 1 only in IDLE; a request is accepted at the rising edge where req_valid and req_ready are both 1.
REQ-019 On acceptance, req_write, word index (req_addr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]), req_wdata and req_strb SHALL be captured; later input changes are ignored.
REQ-020 IDLE -> WAIT on acceptance when LATENCY > 0, loading a 4-bit counter with LATENCY-1; IDLE -> RESP on acceptance when LATENCY = 0.
REQ-021 WAIT SHALL decrement the counter each cycle and go to RESP at the edge where the counter is 0.
REQ-022 If a request is accepted at edge k, resp_valid SHALL first be 1 in the cycle following edge k+LATENCY.
REQ-023 The memory write and the read sample SHALL happen at the edge entering RESP; write updates only the bytes whose strobe bit is 1.
REQ-024 resp_valid, resp_rdata and resp_err SHALL hold stable in RESP until resp_ready = 1; RESP -> IDLE at that edge.
REQ-025 A request presented in the cycle RESP completes is not accepted; req_ready rises in the next cycle (minimum 2-cycle turnaround at LATENCY = 0).
REQ-026 A read of a word written by the preceding transaction SHALL return the merged new data.
REQ-027 With the check enabled (REQ-033), resp_err = 1 and no memory write when the request's byte-offset bits are nonzero; resp_rdata = 0 on error.
REQ-028 Write with req_strb = 0 SHALL complete normally with memory unchanged.

Reset
REQ-029 rst = 1 at a rising edge SHALL force IDLE, counter 0, req_ready = 1 after the edge, resp_valid = 0, resp_err = 0, resp_rdata = 0.
REQ-030 Reset mid-transaction (WAIT or RESP) SHALL drop it; a write not yet committed (still in WAIT) SHALL NOT reach memory.
REQ-031 Memory array contents SHALL NOT be cleared by reset.
REQ-032 rst has priority over every simultaneous handshake event.

Configuration
REQ-033 Macro WAIT_DMEM_MISALIGN_CHECK_EN: defined -> misaligned requests flagged per REQ-027; undefined -> byte-offset bits ignored, resp_err tied to 0, access uses the word index.

Verification
REQ-034 LATENCY=2: write 0xDEADBEEF to 0x010, strb 0xF; read 0x010 -> resp_valid 3 cycles after each accept, rdata 0xDEADBEEF, err 0.
REQ-035 Strobe merge: word 0x020 = 0x11223344, write 0xAABBCCDD strb 0b0101 -> read 0x020 returns 0x11BB33DD.
REQ-036 Backpressure: hold resp_ready = 0 for 5 cycles -> resp_valid/rdata stable, req_ready 0 throughout; accept on 6th.
REQ-037 Reset in WAIT of write 0xCAFEF00D to 0x030 (old 0x0) -> after reset read 0x030 returns 0x00000000, req_ready 1 first cycle after reset.
REQ-038 Macro defined: read 0x013 -> resp_err 1, rdata 0; write 0x012 -> err 1, word 0x010 unchanged; macro undefined: read 0x013 returns word 0x010, err 0.
REQ-039 LATENCY=0: back-to-back requests -> resp_valid one cycle after each accept, accepts no closer than 2 cycles apart.

Source files
------------

// File: rtl/wait_data_memory.sv
// wait_data_memory: single-port word memory behind a valid/ready request
// channel and a valid/ready response channel. Each request spends LATENCY
// wait states before its response; only one transaction is in flight.
// Optional build macro: WAIT_DMEM_MISALIGN_CHECK_EN flags requests whose
// byte-offset address bits are nonzero (resp_err = 1, no memory write).
module wait_data_memory #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_strb,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned OFFB  = $clog2(NB);
  localparam int unsigned IDXW  = ADDR_WIDTH - OFFB;
  localparam int unsigned DEPTH = 1 << IDXW;
  localparam logic [3:0]  LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;

  // Request fields captured at acceptance
  logic            r_write;
  logic [IDXW-1:0] r_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [NB-1:0]   r_strb;
  logic            r_misal;

  // Registered outputs
  logic                  r_req_ready;
  logic                  r_resp_valid;
  logic [DATA_WIDTH-1:0] r_resp_rdata;
  logic                  r_resp_err;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic            w_accept;
  logic            w_enter_resp;
  logic            w_req_misal;
  logic [IDXW-1:0] w_req_idx;
  logic            w_cur_write;
  logic [IDXW-1:0] w_cur_idx;
  logic [DATA_WIDTH-1:0] w_cur_wdata;
  logic [NB-1:0]   w_cur_strb;
  logic            w_cur_misal;
  logic            w_err;

  assign w_req_idx   = req_addr[ADDR_WIDTH-1:OFFB];
  assign w_req_misal = |req_addr[OFFB-1:0];
  assign w_accept    = req_valid && (r_state == S_IDLE);

  // With zero latency RESP is entered on the accepting edge, before the
  // capture registers hold the request, so the live inputs are used then.
  assign w_cur_write = (r_state == S_IDLE) ? req_write   : r_write;
  assign w_cur_idx   = (r_state == S_IDLE) ? w_req_idx   : r_idx;
  assign w_cur_wdata = (r_state == S_IDLE) ? req_wdata   : r_wdata;
  assign w_cur_strb  = (r_state == S_IDLE) ? req_strb    : r_strb;
  assign w_cur_misal = (r_state == S_IDLE) ? w_req_misal : r_misal;

`ifdef WAIT_DMEM_MISALIGN_CHECK_EN
  assign w_err = w_cur_misal;
`else
  logic w_unused_misal;
  assign w_unused_misal = w_cur_misal;
  assign w_err = 1'b0;
`endif

  assign w_enter_resp = (w_state_nxt == S_RESP) && (r_state != S_RESP);

  // State and wait counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and wait-counter logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (LATENCY == 0) begin
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = LAT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Capture the request at acceptance; later input changes are ignored
  always_ff @(posedge clk) begin
    if (!rst && w_accept) begin
      r_write <= req_write;
      r_idx   <= w_req_idx;
      r_wdata <= req_wdata;
      r_strb  <= req_strb;
      r_misal <= w_req_misal;
    end
  end

  // Commit byte-masked writes on the edge entering RESP; never cleared by reset
  always_ff @(posedge clk) begin
    if (!rst && w_enter_resp && w_cur_write && !w_err) begin
      for (int b = 0; b < NB; b++) begin
        if (w_cur_strb[b]) begin
          r_mem[w_cur_idx][b*8 +: 8] <= w_cur_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Handshake flags follow the next state; response payload sampled entering RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_req_ready  <= (w_state_nxt == S_IDLE);
      r_resp_valid <= (w_state_nxt == S_RESP);
      if (w_enter_resp) begin
        r_resp_err   <= w_err;
        r_resp_rdata <= (w_cur_write || w_err) ? '0 : r_mem[w_cur_idx];
      end else if ((r_state == S_RESP) && resp_ready) begin
        r_resp_err   <= 1'b0;
        r_resp_rdata <= '0;
      end
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_wait_data_memory.sv
// Self-checking bench for wait_data_memory: LATENCY=2 instance checked every
// cycle against an edge-counting transaction model, plus a LATENCY=0 instance
// exercised back-to-back.
module tb_wait_data_memory;

  localparam int unsigned LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  logic        req_valid0, req_ready0, req_write0;
  logic [9:0]  req_addr0;
  logic [31:0] req_wdata0;
  logic [3:0]  req_strb0;
  logic        resp_valid0, resp_ready0, resp_err0;
  logic [31:0] resp_rdata0;

  wait_data_memory #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  wait_data_memory #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .req_strb(req_strb0),
    .resp_valid(resp_valid0), .resp_ready(resp_ready0),
    .resp_rdata(resp_rdata0), .resp_err(resp_err0)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction model: a request accepted at edge k is answered at edge k+LAT
  int          edge_n      = 0;
  bit          m_busy      = 1'b0;
  bit          m_acc       = 1'b0;
  bit          m_rst_seen  = 1'b0;
  int          m_resp_edge = 0;
  int          m_acc_edge  = 0;
  bit          m_wr;
  logic [9:0]  m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_strb;
  logic [31:0] m_rdata     = 32'h0;
  bit          m_err       = 1'b0;
  logic [31:0] mm [0:255];

  function automatic bit misaligned(input logic [9:0] a);
`ifdef WAIT_DMEM_MISALIGN_CHECK_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    bit vis;
    edge_n = edge_n + 1;
    m_acc  = 1'b0;
    if (rst) begin
      m_busy     = 1'b0;
      m_rst_seen = 1'b1;
    end else begin
      m_rst_seen = 1'b0;
      vis = m_busy && (edge_n > m_resp_edge);
      if (vis && resp_ready) begin
        m_busy = 1'b0;
      end else if (!m_busy && req_valid) begin
        m_busy = 1'b1; m_acc = 1'b1; m_acc_edge = edge_n;
        m_resp_edge = edge_n + int'(LAT);
        m_wr = req_write; m_addr = req_addr; m_wdata = req_wdata; m_strb = req_strb;
      end
      if (m_busy && edge_n == m_resp_edge) begin
        m_err = misaligned(m_addr);
        if (m_err || m_wr) m_rdata = 32'h0;
        else               m_rdata = mm[m_addr[9:2]];
        if (m_wr && !m_err)
          for (int b = 0; b < 4; b++)
            if (m_strb[b]) mm[m_addr[9:2]][b*8 +: 8] = m_wdata[b*8 +: 8];
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("req_ready", 32'(req_ready), 32'(!m_busy));
      chk("resp_valid", 32'(resp_valid), 32'(m_busy && edge_n >= m_resp_edge));
      if (m_busy && edge_n >= m_resp_edge) begin
        chk("resp_rdata", resp_rdata, m_rdata);
        chk("resp_err", 32'(resp_err), 32'(m_err));
      end
      if (m_rst_seen) begin
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", 32'(resp_err), 32'h0);
      end
    end
  end

  task automatic drive(input bit wr, input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
    bit ok = 1'b0;
    req_write = wr; req_addr = a; req_wdata = d; req_strb = s; req_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = m_acc;
    end
    chk("accept", 32'(ok), 32'h1);
    req_valid = 1'b0;
    req_write = 1'($urandom); req_addr = 10'($urandom);
    req_wdata = $urandom;     req_strb = 4'($urandom);
  endtask

  task automatic finish_resp(input bit rnd);
    for (int i = 0; i < 200 && m_busy; i++) begin
      resp_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
    end
    chk("drain", 32'(m_busy), 32'h0);
    resp_ready = 1'b0;
  endtask

  // Directed transaction with literal expectations and optional backpressure
  task automatic lit(input bit wr, input logic [9:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic [31:0] er, input bit ee, input int hold);
    int k;
    bit seen = 1'b0;
    resp_ready = 1'b0;
    drive(wr, a, d, s);
    k = m_acc_edge;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (resp_valid === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    chk("lit_seen", 32'(seen), 32'h1);
    chk("lit_latency", 32'(edge_n - k), 32'(LAT));
    chk("lit_rdata", resp_rdata, er);
    chk("lit_err", 32'(resp_err), 32'(ee));
    chk("model_rdata", m_rdata, er);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid), 32'h1);
      chk("hold_ready", 32'(req_ready), 32'h0);
      chk("hold_rdata", resp_rdata, er);
    end
    finish_resp(1'b0);
    chk("after_ready", 32'(req_ready), 32'h1);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] exp0 [0:3];
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_strb = '0;
    resp_ready = 1'b0;
    req_valid0 = 1'b0; req_write0 = 1'b0; req_addr0 = '0; req_wdata0 = '0; req_strb0 = '0;
    resp_ready0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cmp_en = 1'b1;
    rst = 1'b0;

    // Known contents for words 0..15
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 10'(i * 4), (i == 8) ? 32'h11223344 : (i == 12) ? 32'h0 : $urandom, 4'hF);
      finish_resp(1'b0);
    end

    lit(1'b1, 10'h010, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 0);
    lit(1'b0, 10'h010, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0);
    lit(1'b1, 10'h020, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0, 0);
    lit(1'b0, 10'h020, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 0);
    lit(1'b0, 10'h010, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 5);
    lit(1'b1, 10'h020, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0, 0);
    lit(1'b0, 10'h020, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 0);

    // Reset while the write is still waiting: it must not commit
    drive(1'b1, 10'h030, 32'hCAFEF00D, 4'hF);
    pulse_rst();
    chk("ready_after_rst", 32'(req_ready), 32'h1);
    lit(1'b0, 10'h030, 32'h0, 4'h0, 32'h0, 1'b0, 0);

`ifdef WAIT_DMEM_MISALIGN_CHECK_EN
    lit(1'b0, 10'h013, 32'h0, 4'h0, 32'h0, 1'b1, 0);
    lit(1'b1, 10'h012, 32'h12345678, 4'hF, 32'h0, 1'b1, 0);
    lit(1'b0, 10'h010, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0);
`else
    lit(1'b0, 10'h013, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0);
    lit(1'b1, 10'h012, 32'h12345678, 4'hF, 32'h0, 1'b0, 0);
    lit(1'b0, 10'h010, 32'h0, 4'h0, 32'h12345678, 1'b0, 0);
`endif

    // Randomized traffic with random backpressure and occasional resets
    for (int t = 0; t < 150; t++) begin
      logic [9:0] a;
      a = 10'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 3) == 0) a = a | 10'($urandom_range(1, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      drive(1'($urandom), a, $urandom, 4'($urandom));
      if ($urandom_range(0, 15) == 0) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        pulse_rst();
      end
      finish_resp(1'b1);
    end

    // LATENCY=0 instance: request held valid, response always accepted
    cmp_en = 1'b0;
    exp0[0] = 32'h0; exp0[1] = 32'h55AA1234; exp0[2] = 32'h0; exp0[3] = 32'h55AAFFFF;
    resp_ready0 = 1'b1;
    req_valid0 = 1'b1; req_write0 = 1'b1; req_addr0 = 10'h008;
    req_wdata0 = 32'h55AA1234; req_strb0 = 4'hF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i % 2 == 0) begin
        chk("l0_ready_busy", 32'(req_ready0), 32'h0);
        chk("l0_valid", 32'(resp_valid0), 32'h1);
        chk("l0_rdata", resp_rdata0, exp0[i / 2]);
        chk("l0_err", 32'(resp_err0), 32'h0);
        case (i / 2)
          0: begin req_write0 = 1'b0; req_wdata0 = 32'hFFFFFFFF; end
          1: begin req_write0 = 1'b1; req_wdata0 = 32'h0000FFFF; req_strb0 = 4'b0011; end
          default: begin req_write0 = 1'b0; req_strb0 = 4'hF; end
        endcase
      end else begin
        chk("l0_ready_idle", 32'(req_ready0), 32'h1);
        chk("l0_valid_idle", 32'(resp_valid0), 32'h0);
      end
    end
    req_valid0 = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1);
  end

endmodule
